// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder: word/lane/counter widths,
// the FSM state encoding and the address-error rule.
package mem_resp_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;
  localparam int LAT_W  = 4;

  // FSM state encoding kept as plain constants for legacy tool compatibility.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  // A byte address is bad when it is not word aligned or points past the array.
  function automatic logic addr_error(input logic [WORD_W-1:0] addr,
                                      input int unsigned depth_words);
    logic [WORD_W-1:0] word_idx;
    word_idx = {2'b00, addr[WORD_W-1:2]};
    return (addr[1:0] != 2'b00) || (word_idx >= WORD_W'(depth_words));
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between an initiator (master) and the data memory
// responder (slave).
interface data_mem_responder_if;
  import mem_resp_pkg::*;

  logic              req;
  logic              we;
  logic [WORD_W-1:0] a;
  logic [WORD_W-1:0] wd;
  logic [BE_W-1:0]   be;
  logic              ready;
  logic              rvalid;
  logic [WORD_W-1:0] rd;
  logic              err;
  logic              rready;

  modport master (output req, we, a, wd, be, rready,
                  input  ready, rvalid, rd, err);
  modport slave  (input  req, we, a, wd, be, rready,
                  output ready, rvalid, rd, err);

endinterface

// File: rtl/data_mem_responder_byte_merge.sv
// Builds the word to be written from the stored word, the write data and the
// lane enables. Lane merging is compiled in only when MEM_BYTE_WRITE_EN is
// defined; otherwise the write data passes straight through.
module byte_merge
  import mem_resp_pkg::*;
(
  input  logic [WORD_W-1:0] old_word,
  input  logic [WORD_W-1:0] wd,
  input  logic [BE_W-1:0]   be,
  output logic [WORD_W-1:0] new_word
);

`ifdef MEM_BYTE_WRITE_EN
  // Take each byte from wd where its lane is enabled, else keep the stored byte.
  always_comb begin
    new_word = old_word;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) begin
        new_word[8*i +: 8] = wd[8*i +: 8];
      end else begin
        new_word[8*i +: 8] = old_word[8*i +: 8];
      end
    end
  end
`else
  logic unused_s;
  assign unused_s = ^{old_word, be};

  // Full-word write: incoming data replaces the stored word outright.
  always_comb begin
    new_word = wd;
  end
`endif

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder with a fixed response latency.
// Optional macro: MEM_BYTE_WRITE_EN enables per-lane write masking via BE.
module data_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
)
(
  input  logic                 clk,
  input  logic                 rst_n,
  data_mem_responder_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(LATENCY);
  localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

  state_t            state_r;
  logic [LAT_W-1:0]  cnt_r;
  logic              ready_r;
  logic              rvalid_r;
  logic              err_r;
  logic [WORD_W-1:0] rd_r;
  logic              pend_err_r;
  logic [WORD_W-1:0] pend_rd_r;

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  logic              accept_s;
  logic              addr_err_s;
  logic [IDX_W-1:0]  idx_s;
  logic [WORD_W-1:0] old_word_s;
  logic [WORD_W-1:0] new_word_s;
  logic [WORD_W-1:0] resp_rd_s;

  assign accept_s   = bus.req & ready_r;
  assign addr_err_s = addr_error(bus.a, DEPTH_WORDS);
  assign idx_s      = bus.a[IDX_W+1:2];
  assign old_word_s = mem[idx_s];

  // Reads return the stored word (no write can land on the same edge);
  // writes and errors return zero.
  assign resp_rd_s = (!addr_err_s && !bus.we) ? old_word_s : {WORD_W{1'b0}};

  assign bus.ready  = ready_r;
  assign bus.rvalid = rvalid_r;
  assign bus.rd     = rd_r;
  assign bus.err    = err_r;

  byte_merge u_byte_merge (
    .old_word (old_word_s),
    .wd       (bus.wd),
    .be       (bus.be),
    .new_word (new_word_s)
  );

  // Commit valid writes on the accepting edge; the array is never reset.
  always_ff @(posedge clk) begin
    if (accept_s && bus.we && !addr_err_s) begin
      mem[idx_s] <= new_word_s;
    end
  end

  // Request/latency/response sequencing with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {LAT_W{1'b0}};
      ready_r    <= 1'b0;
      rvalid_r   <= 1'b0;
      err_r      <= 1'b0;
      rd_r       <= {WORD_W{1'b0}};
      pend_err_r <= 1'b0;
      pend_rd_r  <= {WORD_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            ready_r <= 1'b0;
            if (LATENCY == 0) begin
              state_r  <= ST_RESP;
              rvalid_r <= 1'b1;
              rd_r     <= resp_rd_s;
              err_r    <= addr_err_s;
            end else begin
              state_r    <= ST_WAIT;
              cnt_r      <= LAT_INIT;
              pend_rd_r  <= resp_rd_s;
              pend_err_r <= addr_err_s;
            end
          end else begin
            ready_r <= 1'b1;
          end
        end
        ST_WAIT: begin
          cnt_r <= cnt_r - LAT_ONE;
          if (cnt_r <= LAT_ONE) begin
            state_r  <= ST_RESP;
            rvalid_r <= 1'b1;
            rd_r     <= pend_rd_r;
            err_r    <= pend_err_r;
          end
        end
        ST_RESP: begin
          if (bus.rready) begin
            state_r  <= ST_IDLE;
            ready_r  <= 1'b1;
            rvalid_r <= 1'b0;
            rd_r     <= {WORD_W{1'b0}};
            err_r    <= 1'b0;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          cnt_r    <= {LAT_W{1'b0}};
          ready_r  <= 1'b0;
          rvalid_r <= 1'b0;
          rd_r     <= {WORD_W{1'b0}};
          err_r    <= 1'b0;
        end
      endcase
    end
  end

endmodule
